// File: rtl/interrupt_timer.sv
// Memory-mapped interval timer with compare match, auto-reload and level interrupt.
// Define INTERRUPT_TIMER_PRESCALER_EN to build the 16-bit PRESCALE register and prescaler.
module interrupt_timer #(
  parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  output logic        interrupt_o,
  input  logic        chip_select_i,
  input  logic [3:0]  addr_i,
  input  logic        read_enable_i,
  output logic [31:0] read_data_o,
  input  logic [31:0] write_data_i,
  input  logic [3:0]  write_mask_i
);
  typedef enum logic [1:0] {IDLE, RUNNING, EXPIRED} state_t;

  state_t      state;
  logic [2:0]  ctrl;
  logic        pending;
  logic [31:0] count, compare;
  logic [31:0] bmask, rdata;
  logic [2:0]  ctrl_nx;
  logic        wr, rd, wr_ctrl, wr_stat, wr_count, wr_cmp;
  logic        stop, start, psc_hit, tick, match;

  assign bmask    = {{8{write_mask_i[3]}}, {8{write_mask_i[2]}},
                     {8{write_mask_i[1]}}, {8{write_mask_i[0]}}};
  assign wr       = chip_select_i && (|write_mask_i);
  assign rd       = chip_select_i && read_enable_i;
  assign wr_ctrl  = wr && (addr_i == 4'd0);
  assign wr_stat  = wr && (addr_i == 4'd1);
  assign wr_count = wr && (addr_i == 4'd2);
  assign wr_cmp   = wr && (addr_i == 4'd3);
  assign ctrl_nx  = (ctrl & ~bmask[2:0]) | (write_data_i[2:0] & bmask[2:0]);

  // The new EN value (after byte masking) decides the state change.
  assign stop  = wr_ctrl && !ctrl_nx[0];
  assign start = wr_ctrl && ctrl_nx[0] && (state != RUNNING);

`ifdef INTERRUPT_TIMER_PRESCALER_EN
  logic [15:0] prescale, pcnt;
  logic        wr_psc;
  assign wr_psc  = wr && (addr_i == 4'd4);
  assign psc_hit = (pcnt == prescale);
`else
  assign psc_hit = 1'b1;
`endif

  assign tick  = (state == RUNNING) && !stop && psc_hit;
  // A bus write to COUNT swallows the compare of a coincident tick.
  assign match = tick && !wr_count && (count == compare);

  always_comb begin
    rdata = '0;
    case (addr_i)
      4'd0: rdata = {29'd0, ctrl};
      4'd1: rdata = {30'd0, state == RUNNING, pending};
      4'd2: rdata = count;
      4'd3: rdata = compare;
`ifdef INTERRUPT_TIMER_PRESCALER_EN
      4'd4: rdata = {16'd0, prescale};
`endif
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state       <= IDLE;
      ctrl        <= '0;
      pending     <= 1'b0;
      count       <= '0;
      compare     <= RESET_COMPARE;
      interrupt_o <= 1'b0;
      read_data_o <= '0;
    end else begin
      if (rd) read_data_o <= rdata;
      interrupt_o <= pending && ctrl[2];
      if (wr_ctrl) ctrl <= ctrl_nx;
      if (wr_cmp)  compare <= (compare & ~bmask) | (write_data_i & bmask);

      // Hardware set wins over a same-cycle W1C.
      if (match)
        pending <= 1'b1;
      else if (wr_stat && write_mask_i[0] && write_data_i[0])
        pending <= 1'b0;

      if (stop)
        state <= IDLE;
      else if (start)
        state <= RUNNING;
      else if (match && !ctrl[1])
        state <= EXPIRED;

      if (wr_count)
        count <= (count & ~bmask) | (write_data_i & bmask);
      else if (start && state == EXPIRED)
        count <= '0;
      else if (tick) begin
        if (!match)      count <= count + 32'd1;
        else if (ctrl[1]) count <= '0;
      end
    end
  end

`ifdef INTERRUPT_TIMER_PRESCALER_EN
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      prescale <= '0;
      pcnt     <= '0;
    end else begin
      if (wr_psc) prescale <= (prescale & ~bmask[15:0]) | (write_data_i[15:0] & bmask[15:0]);
      if (start)
        pcnt <= '0;
      else if (state == RUNNING && !stop)
        pcnt <= psc_hit ? 16'd0 : pcnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_interrupt_timer.sv
// Randomized + directed bench for interrupt_timer; a behavioural model feeds a
// scoreboard queue that a negedge monitor drains against interrupt_o/read_data_o.
module tb_interrupt_timer;
  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        interrupt_o;
  logic        chip_select_i = 1'b0;
  logic [3:0]  addr_i = '0;
  logic        read_enable_i = 1'b0;
  logic [31:0] read_data_o;
  logic [31:0] write_data_i = '0;
  logic [3:0]  write_mask_i = '0;

  interrupt_timer dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .interrupt_o(interrupt_o),
    .chip_select_i(chip_select_i), .addr_i(addr_i), .read_enable_i(read_enable_i),
    .read_data_o(read_data_o), .write_data_i(write_data_i), .write_mask_i(write_mask_i));

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  typedef struct { logic [31:0] rd; logic irq; } exp_t;
  exp_t exp_q[$];

  // Reference model: mode 0 = stopped, 1 = counting, 2 = expired.
  int          m_mode;
  logic [2:0]  m_ctrl;
  logic        m_pend, m_irq;
  logic [31:0] m_cnt, m_cmp, m_rd;
  logic [15:0] m_psc, m_pc;

  task automatic model_reset();
    m_mode = 0; m_ctrl = 0; m_pend = 0; m_irq = 0;
    m_cnt = 0; m_cmp = 32'hFFFF_FFFF; m_rd = 0; m_psc = 0; m_pc = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] a);
    case (a)
      4'd0: return {29'd0, m_ctrl};
      4'd1: return {30'd0, m_mode == 1, m_pend};
      4'd2: return m_cnt;
      4'd3: return m_cmp;
      4'd4: return {16'd0, m_psc};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic model_step(input bit cs, input bit re, input logic [3:0] a,
                            input logic [31:0] d, input logic [3:0] m);
    bit wr, tick, set;
    int old_mode;
    logic [2:0] nctrl;
    logic [31:0] t;
    wr = cs && (m != 0);
    old_mode = m_mode;
    if (cs && re) m_rd = model_read(a);
    m_irq = m_pend && m_ctrl[2];
    t = merge({29'd0, m_ctrl}, d, m);
    nctrl = (wr && a == 0) ? t[2:0] : m_ctrl;
    tick = 0; set = 0;
    if (old_mode == 1 && nctrl[0]) begin
      if (m_pc == m_psc) begin tick = 1; m_pc = 0; end
      else m_pc = m_pc + 16'd1;
    end
    if (wr && a == 2) m_cnt = merge(m_cnt, d, m);
    else if (tick) begin
      if (m_cnt == m_cmp) begin
        set = 1;
        if (m_ctrl[1]) m_cnt = 0; else m_mode = 2;
      end else m_cnt = m_cnt + 1;
    end
    if (set) m_pend = 1;
    else if (wr && a == 1 && m[0] && d[0]) m_pend = 0;
    if (wr && a == 3) m_cmp = merge(m_cmp, d, m);
`ifdef INTERRUPT_TIMER_PRESCALER_EN
    if (wr && a == 4) begin t = merge({16'd0, m_psc}, d, m); m_psc = t[15:0]; end
`endif
    if (wr && a == 0) begin
      if (!nctrl[0]) m_mode = 0;
      else if (old_mode != 1) begin
        if (old_mode == 2) m_cnt = 0;
        m_mode = 1; m_pc = 0;
      end
      m_ctrl = nctrl;
    end
  endtask

  task automatic cyc(input bit cs, input bit re, input logic [3:0] a,
                     input logic [31:0] d, input logic [3:0] m);
    exp_t e;
    chip_select_i = cs; read_enable_i = re; addr_i = a; write_data_i = d; write_mask_i = m;
    @(posedge clk_i);
    model_step(cs, re, a, d, m);
    e.rd = m_rd; e.irq = m_irq;
    exp_q.push_back(e);
    #1;
    chip_select_i = 0; read_enable_i = 0; write_mask_i = 0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0);
  endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m = 4'hF);
    cyc(1, 0, a, d, m);
  endtask
  task automatic rd(input logic [3:0] a);
    cyc(1, 1, a, 0, 0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Direct check of the read just issued, against a fixed value.
  task automatic expect_rd(input string name, input logic [31:0] req);
    @(negedge clk_i);
    chk(name, read_data_o, req);
  endtask

  always @(negedge clk_i) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("irq", {31'd0, interrupt_o}, {31'd0, e.irq});
      chk("rdata", read_data_o, e.rd);
    end
  end

  task automatic async_reset();
    @(negedge clk_i);
    #1 reset_n_i = 0;
    #1;
    chk("rst_irq", {31'd0, interrupt_o}, 32'd0);
    chk("rst_rdata", read_data_o, 32'd0);
    model_reset();
    repeat (2) @(posedge clk_i);
    #2 reset_n_i = 1;
  endtask

  initial begin
    logic [3:0] a;
    logic [31:0] d;
    int k;
    model_reset();
    #12;
    chk("por_irq", {31'd0, interrupt_o}, 32'd0);
    chk("por_rdata", read_data_o, 32'd0);
    #6 reset_n_i = 1;
    for (int i = 0; i < 5; i++) rd(4'(i));
    rd(3); expect_rd("reset_compare", 32'hFFFF_FFFF);

    // One-shot
    wr(3, 3); wr(4, 0); wr(2, 0); wr(0, 5);
    repeat (6) rd(2);
    rd(1); expect_rd("oneshot_status", 32'h1);
    rd(2); expect_rd("oneshot_hold", 32'd3);
    idle(2);

    // Periodic with W1C
    wr(0, 0); wr(2, 0); wr(3, 1); wr(4, 2); wr(0, 7);
    idle(20);
    wr(1, 1, 4'b0001);
    idle(4);

    // Wrap
    wr(0, 0); wr(1, 1, 4'b0001); wr(3, 5); wr(4, 0); wr(2, 32'hFFFF_FFFF); wr(0, 1);
    rd(2); rd(2); expect_rd("wrap_count", 32'd0);
    rd(1); expect_rd("wrap_nopend", 32'h2);

    // Collisions
    wr(0, 0); wr(1, 1, 4'b0001); wr(2, 0); wr(3, 2); wr(0, 5);
    idle(2); wr(1, 1, 4'b0001);
    rd(1); expect_rd("w1c_vs_match", 32'h1);
    wr(0, 0); wr(1, 1, 4'b0001); wr(3, 100); wr(2, 0); wr(0, 1);
    wr(2, 9);
    rd(2); expect_rd("count_wr_vs_tick", 32'd9);
    wr(0, 0);

    // Masking and unmapped addresses
    wr(3, 0); wr(3, 32'hAABBCCDD, 4'b0101);
    rd(3); expect_rd("mask_compare", 32'h00BB00DD);
    wr(15, 32'h1234_5678);
    rd(15); expect_rd("addr15", 32'd0);

    // Random traffic
    wr(0, 0); wr(4, 1);
    for (int i = 0; i < 1500; i++) begin
      k = $urandom_range(0, 9);
      a = ($urandom_range(0, 5) == 5) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(0, 4));
      d = $urandom;
      case (a)
        4'd0: d = d & 32'h7;
        4'd2: d = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | (d & 32'hF)) : (d & 32'hF);
        4'd3: d = d & 32'hF;
        4'd4: d = d & 32'h3;
        default: ;
      endcase
      if (k < 5) idle(1);
      else if (k < 7) rd(a);
      else wr(a, d, 4'($urandom_range(1, 15)));
    end

    // Reset while running with PENDING set
    wr(0, 0); wr(3, 2); wr(4, 0); wr(2, 0); wr(0, 7);
    idle(6);
    async_reset();
    for (int i = 0; i < 5; i++) rd(4'(i));
    rd(3); expect_rd("post_rst_compare", 32'hFFFF_FFFF);
    idle(3);

    repeat (2) @(negedge clk_i);
    if (exp_q.size() != 0) chk("drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
